if_prefetch: RTL

- Sequential instruction-fetch front end for the RV64 core. Replaces combinational per-cycle fetch with a request/response memory port and a DEPTH-entry prefetch FIFO.
- Sits between the PC/redirect logic of EX and the if_id pipeline register.
- Absorbs memory latency and downstream stalls; on jump/branch redirect it flushes queued instructions and discards stale in-flight responses.

---
 rtl/if_prefetch_pkg.sv | 15 +
 rtl/if_prefetch_if.sv | 32 +++
 rtl/if_fifo.sv | 54 +++++
 rtl/if_prefetch.sv | 104 ++++++++++
 4 files changed

// File: rtl/if_prefetch_pkg.sv
// Shared definitions for the instruction-fetch front end: reset PC, instruction
// width, canonical NOP and the fetch state encoding.
package if_prefetch_pkg;

  localparam logic [63:0]  DEF_RESET_PC = 64'h8000_0000;
  localparam int unsigned  DEF_INST_W   = 32;
  localparam logic [31:0]  NOP_INST     = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_prefetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/response port, redirect
// input and the if_id-facing instruction handshake.
interface if_prefetch_if
  import if_prefetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned INST_W = DEF_INST_W
);
  logic              imem_req_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic              imem_ready_i;
  logic              imem_rvalid_i;
  logic [63:0]       imem_rdata_i;
  logic              jump_flag_i;
  logic [ADDR_W-1:0] jump_addr_i;
  logic              inst_valid_o;
  logic              inst_ready_i;
  logic [INST_W-1:0] inst_o;
  logic [ADDR_W-1:0] inst_addr_o;

  modport master (
    output imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_addr_o,
    input  imem_ready_i, imem_rvalid_i, imem_rdata_i,
           jump_flag_i, jump_addr_i, inst_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_addr_o,
    output imem_ready_i, imem_rvalid_i, imem_rdata_i,
           jump_flag_i, jump_addr_i, inst_ready_i
  );
endinterface

// File: rtl/if_fifo.sv
// Synchronous prefetch FIFO with single-cycle flush; DEPTH must be a power of two
// so the read/write pointers wrap naturally.
module if_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 96
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; emptiness is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/if_prefetch.sv
// Sequential instruction fetch: one outstanding doubleword request, word select,
// redirect flush with stale-response drop. Define IF_TRACE_EN for handshake trace.
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 64,
  parameter int unsigned       INST_W     = DEF_INST_W,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEF_RESET_PC)
) (
  input  logic               clk,
  input  logic               rst,
  if_prefetch_if.master      bus
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned EW = ADDR_W + INST_W;

  fetch_state_t      state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] req_pc;
  logic [INST_W-1:0] sel_word;
  logic [EW-1:0]     head;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic              req;
  logic              push;
  logic              pop;

  assign req = !rst && (state == ST_RUN) && (count < CW'(FIFO_DEPTH))
               && !bus.jump_flag_i;

  assign bus.imem_req_o  = req;
  assign bus.imem_addr_o = {fetch_pc[ADDR_W-1:3], 3'b000};

  assign sel_word = fetch_pc[2] ? bus.imem_rdata_i[63:32] : bus.imem_rdata_i[31:0];

  assign push = (state == ST_WAIT) && bus.imem_rvalid_i && !bus.jump_flag_i && !full;
  assign pop  = !empty && bus.inst_ready_i;

  if_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.jump_flag_i),
    .push      (push),
    .push_data ({req_pc, sel_word}),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign bus.inst_valid_o = !empty;
  assign bus.inst_o       = empty ? '0 : head[INST_W-1:0];
  assign bus.inst_addr_o  = empty ? '0 : head[EW-1:INST_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      fetch_pc <= RESET_PC & ~ADDR_W'(3);
      req_pc   <= RESET_PC & ~ADDR_W'(3);
    end else begin
      case (state)
        ST_RUN: begin
          if (req && bus.imem_ready_i) begin
            state  <= ST_WAIT;
            req_pc <= fetch_pc;
          end
        end
        ST_WAIT: begin
          if (bus.imem_rvalid_i) begin
            state <= ST_RUN;
            if (!bus.jump_flag_i) fetch_pc <= fetch_pc + ADDR_W'(4);
          end else if (bus.jump_flag_i) begin
            state <= ST_DROP;
          end
        end
        // The stale response retires the outstanding request even if another
        // redirect lands on the same cycle; staying in DROP would wait forever.
        ST_DROP: begin
          if (bus.imem_rvalid_i) state <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
      if (bus.jump_flag_i) fetch_pc <= bus.jump_addr_i & ~ADDR_W'(3);
    end
  end

`ifdef IF_TRACE_EN
  always_ff @(posedge clk) begin
    if (!rst && bus.inst_valid_o && bus.inst_ready_i)
      $display("IFU: pc_addr: %x inst: %x", bus.inst_addr_o, bus.inst_o);
    if (!rst && bus.jump_flag_i)
      $display("IFU: redirect target: %x", bus.jump_addr_i);
  end
`else
  // Trace disabled: no simulation-only statements in this build.
`endif

endmodule
